ysyx_23060096_rf_wb_arbiter: RTL and testbench



---
 rtl/ysyx_23060096_pkg.sv | 12 +
 rtl/ysyx_23060096_rf_wb_arbiter_if.sv | 15 +
 rtl/ysyx_23060096_wb_scoreboard.sv | 63 ++++++
 rtl/ysyx_23060096_rf_wb_arbiter.sv | 96 +++++++++
 tb/tb_ysyx_23060096_rf_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060096_pkg.sv
// Shared constants for the NPC register-file write-back path.
package ysyx_23060096_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NREG       = 2 ** ADDR_WIDTH;

  // Write-back source identifiers; also the encoding of the round-robin pointer.
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060096_rf_wb_arbiter_if.sv
// One valid/ready write-back channel: a source drives address and data, the arbiter returns ready.
interface ysyx_23060096_rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = ysyx_23060096_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ysyx_23060096_pkg::DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output addr, output data, input  ready);
  modport slave  (input  valid, input  addr, input  data, output ready);

endinterface

// File: rtl/ysyx_23060096_wb_scoreboard.sv
// Busy bitmap of registers with writes in flight, RAW hazard lookups and sticky protocol-error flag.
module ysyx_23060096_wb_scoreboard #(
  parameter int ADDR_WIDTH = ysyx_23060096_pkg::ADDR_WIDTH,
  parameter int NREG       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [ADDR_WIDTH-1:0] chk_ra,
  input  logic [ADDR_WIDTH-1:0] chk_rb,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  hazard_d,
  output logic [NREG-1:0]       busy_vec,
  output logic                  sb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            sb_err_q, sb_err_d;
  logic            alloc_set;
  logic            alloc_err;
  logic            wb_err;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    busy_d    = busy_q;
    alloc_set = alloc_valid && (alloc_addr != '0);

    // The clear is applied before the set so a same-cycle re-allocation keeps the bit high.
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (alloc_set) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;

    alloc_err = alloc_set && busy_q[alloc_addr] && !(clr_en && (clr_addr == alloc_addr));
    wb_err    = wb_en && !busy_q[wb_addr];
    sb_err_d  = sb_err_q || alloc_err || wb_err;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  // No bypass: a register reads busy until the edge after its write is committed.
  assign hazard_a = (chk_ra != '0) && busy_q[chk_ra];
  assign hazard_b = (chk_rb != '0) && busy_q[chk_rb];
  assign hazard_d = (chk_rd != '0) && busy_q[chk_rd];
  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EXU and LSU write-back.
module ysyx_23060096_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = ysyx_23060096_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ysyx_23060096_pkg::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic [ADDR_WIDTH-1:0]        chk_ra,
  input  logic [ADDR_WIDTH-1:0]        chk_rb,
  input  logic [ADDR_WIDTH-1:0]        chk_rd,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic                         hazard_d,
  ysyx_23060096_rf_wb_arbiter_if.slave s0,
  ysyx_23060096_rf_wb_arbiter_if.slave s1,
  output logic                         rf_w_en,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [(2**ADDR_WIDTH)-1:0]   busy_vec,
  output logic                         sb_err
);

  import ysyx_23060096_pkg::*;

  logic                  last_grant_q, last_grant_d;
  logic                  rf_w_en_q, rf_w_en_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  gnt0, gnt1, xfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    // A tie goes to whichever source did not win the previous transfer.
    if (s0.valid && s1.valid) gnt0 = (last_grant_q == SRC_LSU);
    else                      gnt0 = s0.valid;
    gnt1 = s1.valid && !gnt0;
    xfer = gnt0 || gnt1;

    win_addr = gnt1 ? s1.addr : s0.addr;
    win_data = gnt1 ? s1.data : s0.data;

    last_grant_d = xfer ? (gnt1 ? SRC_LSU : SRC_EXU) : last_grant_q;

    // Address-0 writes are accepted but never reach the register file.
    rf_w_en_d  = xfer && (win_addr != '0);
    rf_waddr_d = rf_w_en_d ? win_addr : rf_waddr_q;
    rf_wdata_d = rf_w_en_d ? win_data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_LSU;
      rf_w_en_q    <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_w_en_q    <= rf_w_en_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign s0.ready = gnt0;
  assign s1.ready = gnt1;
  assign rf_w_en  = rf_w_en_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  ysyx_23060096_wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREG       (2 ** ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .clr_en      (rf_w_en_q),
    .clr_addr    (rf_waddr_q),
    .wb_en       (rf_w_en_d),
    .wb_addr     (win_addr),
    .chk_ra      (chk_ra),
    .chk_rb      (chk_rb),
    .chk_rd      (chk_rd),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .hazard_d    (hazard_d),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes; a negedge monitor pops and compares.
module tb_ysyx_23060096_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr;
  logic [AW-1:0] chk_ra, chk_rb, chk_rd;
  logic          hazard_a, hazard_b, hazard_d;
  logic          rf_w_en;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_vec;
  logic          sb_err;

  int  n_checks = 0;
  int  n_errors = 0;
  wb_t exp_q[$];

  ysyx_23060096_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();
  ysyx_23060096_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();

  ysyx_23060096_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .chk_ra      (chk_ra),
    .chk_rb      (chk_rb),
    .chk_rd      (chk_rd),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .hazard_d    (hazard_d),
    .s0          (s0_if),
    .s1          (s1_if),
    .rf_w_en     (rf_w_en),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_valid = 1'b1;
    alloc_addr  = a;
    tick();
    alloc_valid = 1'b0;
  endtask

  // Monitor: every presented register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rf_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        check("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  logic [AW-1:0] s0_addrs [4] = '{5'd10, 5'd12, 5'd14, 5'd0};
  logic [AW-1:0] s1_addrs [4] = '{5'd11, 5'd13, 5'd15, 5'd0};

  initial begin
    int i0, i1;
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_addr = '0;
    chk_ra = '0; chk_rb = '0; chk_rd = '0;
    s0_if.valid = 1'b0; s0_if.addr = '0; s0_if.data = '0;
    s1_if.valid = 1'b0; s1_if.addr = '0; s1_if.data = '0;

    // Reset state and basic single-source write-back with hazard timing.
    do_reset();
    check("rst_rf_w_en", 64'(rf_w_en), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_busy_vec", 64'(busy_vec), 64'd0);
    check("rst_sb_err", 64'(sb_err), 64'd0);

    alloc_valid = 1'b1; alloc_addr = 5'd5; chk_ra = 5'd5; chk_rb = 5'd0;
    settle();
    check("hazard_a_before_alloc", 64'(hazard_a), 64'd0);
    tick();
    alloc_valid = 1'b0;
    settle();
    check("hazard_a_after_alloc", 64'(hazard_a), 64'd1);
    check("hazard_b_x0", 64'(hazard_b), 64'd0);
    check("busy_vec_x5", 64'(busy_vec), 64'h20);
    s0_if.valid = 1'b1; s0_if.addr = 5'd5; s0_if.data = 32'hDEADBEEF;
    expect_wb(5'd5, 32'hDEADBEEF);
    settle();
    check("s0_ready_single", 64'(s0_if.ready), 64'd1);
    tick();
    s0_if.valid = 1'b0;
    check("rf_w_en_t1", 64'(rf_w_en), 64'd1);
    check("hazard_a_t1", 64'(hazard_a), 64'd1);
    tick();
    check("hazard_a_t2", 64'(hazard_a), 64'd0);
    check("rf_w_en_t2", 64'(rf_w_en), 64'd0);

    // Tie right after reset: EXU first, then LSU.
    do_reset();
    alloc(5'd3);
    alloc(5'd4);
    s0_if.valid = 1'b1; s0_if.addr = 5'd3; s0_if.data = 32'h11;
    s1_if.valid = 1'b1; s1_if.addr = 5'd4; s1_if.data = 32'h22;
    expect_wb(5'd3, 32'h11);
    settle();
    check("tie0_s0_ready", 64'(s0_if.ready), 64'd1);
    check("tie0_s1_ready", 64'(s1_if.ready), 64'd0);
    tick();
    expect_wb(5'd4, 32'h22);
    check("tie1_s0_ready", 64'(s0_if.ready), 64'd0);
    check("tie1_s1_ready", 64'(s1_if.ready), 64'd1);
    tick();
    s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    check("tie_second_write_en", 64'(rf_w_en), 64'd1);
    repeat (2) tick();
    check("tie_busy_vec", 64'(busy_vec), 64'd0);
    check("tie_sb_err", 64'(sb_err), 64'd0);

    // Continuous contention for 6 cycles: grants alternate starting with EXU.
    for (int r = 10; r <= 15; r++) alloc(AW'(r));
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      s0_if.valid = 1'b1; s0_if.addr = s0_addrs[i0]; s0_if.data = 32'h1000 + 32'(s0_addrs[i0]);
      s1_if.valid = 1'b1; s1_if.addr = s1_addrs[i1]; s1_if.data = 32'h2000 + 32'(s1_addrs[i1]);
      settle();
      if (k % 2 == 0) begin
        expect_wb(s0_addrs[i0], 32'h1000 + 32'(s0_addrs[i0]));
        check("rr_s0_ready", 64'(s0_if.ready), 64'd1);
        i0++;
      end else begin
        expect_wb(s1_addrs[i1], 32'h2000 + 32'(s1_addrs[i1]));
        check("rr_s1_ready", 64'(s1_if.ready), 64'd1);
        i1++;
      end
      tick();
    end
    s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    check("rr_sb_err", 64'(sb_err), 64'd0);

    // LSU write to x0: accepted, no register-file write, scoreboard untouched.
    alloc(5'd6);
    s1_if.valid = 1'b1; s1_if.addr = 5'd0; s1_if.data = 32'hFFFF;
    settle();
    check("x0_s1_ready", 64'(s1_if.ready), 64'd1);
    tick();
    s1_if.valid = 1'b0;
    check("x0_rf_w_en", 64'(rf_w_en), 64'd0);
    check("x0_rf_waddr_hold", 64'(rf_waddr), 64'd15);
    check("x0_rf_wdata_hold", 64'(rf_wdata), 64'h200F);
    check("x0_busy_vec", 64'(busy_vec), 64'h40);
    check("x0_sb_err", 64'(sb_err), 64'd0);

    // Alloc x7 on the edge that clears x7: set wins, no error.
    alloc(5'd7);
    s0_if.valid = 1'b1; s0_if.addr = 5'd7; s0_if.data = 32'h77;
    expect_wb(5'd7, 32'h77);
    tick();
    s0_if.valid = 1'b0;
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    tick();
    alloc_valid = 1'b0;
    check("realloc_busy7", 64'(busy_vec[7]), 64'd1);
    check("realloc_sb_err", 64'(sb_err), 64'd0);

    // Write-back to never-allocated x9 raises a sticky error.
    s1_if.valid = 1'b1; s1_if.addr = 5'd9; s1_if.data = 32'h99;
    expect_wb(5'd9, 32'h99);
    tick();
    s1_if.valid = 1'b0;
    check("unalloc_sb_err", 64'(sb_err), 64'd1);
    repeat (3) tick();
    check("sticky_sb_err", 64'(sb_err), 64'd1);

    // Reset while an output write is presented discards state.
    do_reset();
    alloc(5'd8);
    s0_if.valid = 1'b1; s0_if.addr = 5'd8; s0_if.data = 32'h88;
    expect_wb(5'd8, 32'h88);
    tick();
    s0_if.valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_rf_w_en", 64'(rf_w_en), 64'd0);
    check("midrst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("midrst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("midrst_busy_vec", 64'(busy_vec), 64'd0);
    check("midrst_sb_err", 64'(sb_err), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    check("pending_expected_writes", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
